// File: rtl/pc_gen.sv
// Fetch-stage program counter: boot handshake, flush/branch redirect, and a
// one-deep buffer that holds a branch taken while fetch is stalled.
module pc_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        STEP      = 4,
  parameter int unsigned        STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               branch_pending_o,
  output logic               pc_misalign_o
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] MASK   = STEP_V - ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              r_pend_vld;
  logic              r_ce;
  logic              r_misalign;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_go;
  logic              w_stall_unused;

  // Only the fetch bit of the stall vector matters here.
  assign w_go           = ~stall[0];
  assign w_stall_unused = ^stall;

  always_comb begin
    w_pc_nxt = r_pc;
    if (flush)                        w_pc_nxt = new_pc;
    else if (w_go && branch_flag_i)   w_pc_nxt = branch_target_address_i;
    else if (w_go && r_pend_vld)      w_pc_nxt = r_pend_tgt;
    else if (w_go)                    w_pc_nxt = r_pc + STEP_V;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VEC;
      r_ce       <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_tgt <= '0;
      r_misalign <= 1'b0;
    end else if (r_state == BOOT) begin
      // pc stays at RESET_VEC so it becomes the first fetched address.
      r_state <= RUN;
      r_ce    <= 1'b1;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= |(w_pc_nxt & MASK);
      if (flush || w_go) begin
        r_pend_vld <= 1'b0;
      end else if (branch_flag_i) begin
        r_pend_vld <= 1'b1;
        r_pend_tgt <= branch_target_address_i;
      end
    end
  end

  assign pc               = r_pc;
  assign ce               = r_ce;
  assign branch_pending_o = r_pend_vld;
  assign pc_misalign_o    = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and random checks of pc_gen against a behavioural fetch-address model.
module tb_pc_gen;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam int unsigned STEP      = 4;
  localparam int unsigned STALL_W   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               branch_pending_o;
  logic               pc_misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_pt;

  pc_gen #(.ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC), .STEP(STEP), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
    .pc(pc), .ce(ce), .branch_pending_o(branch_pending_o), .pc_misalign_o(pc_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_pc = RESET_VEC; m_pv = 0; m_pt = '0;
  endtask

  task automatic model_edge();
    if (!rst) begin model_reset(); return; end
    if (!m_run) begin m_run = 1; return; end
    if (flush) begin
      m_pc = new_pc; m_pv = 0;
    end else if (!stall[0]) begin
      if (branch_flag_i) m_pc = branch_target_address_i;
      else if (m_pv)     m_pc = m_pt;
      else               m_pc = m_pc + STEP;
      m_pv = 0;
    end else if (branch_flag_i) begin
      m_pt = branch_target_address_i; m_pv = 1;
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".pc"},   pc, m_pc);
    cmp({tag, ".ce"},   32'(ce), 32'(m_run));
    cmp({tag, ".pend"}, 32'(branch_pending_o), 32'(m_pv));
    cmp({tag, ".mis"},  32'(pc_misalign_o), 32'((m_pc % STEP) != 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    stall = '0; flush = 0; new_pc = '0; branch_flag_i = 0; branch_target_address_i = '0;
  endtask

  initial begin
    rst = 0; idle(); model_reset();
    #1;
    check_model("reset");
    repeat (3) step("reset_hold");
    cmp("reset.pc_const", pc, 32'h0);
    cmp("reset.ce_const", 32'(ce), 32'h0);

    // Boot then sequential fetch
    rst = 1;
    step("boot");
    cmp("boot.ce", 32'(ce), 32'h1);
    cmp("boot.pc", pc, 32'h0);
    step("seq4");  cmp("seq4.pc", pc, 32'h4);
    step("seq8");  cmp("seq8.pc", pc, 32'h8);

    // Unstalled branch at pc=8
    branch_flag_i = 1; branch_target_address_i = 32'h100;
    step("br");    cmp("br.pc", pc, 32'h100);
    idle();
    step("br+1");  cmp("br1.pc", pc, 32'h104);
    cmp("br1.pend", 32'(branch_pending_o), 32'h0);

    // Stalled branch buffering at pc=0x20
    flush = 1; new_pc = 32'h20;
    step("to20");  idle();
    stall = 6'b000011; branch_flag_i = 1; branch_target_address_i = 32'h400;
    step("st0");   cmp("st0.pend", 32'(branch_pending_o), 32'h1);
    branch_flag_i = 0;
    step("st1");
    step("st2");   cmp("st2.pc", pc, 32'h20);
    stall = '0;
    step("st_rel"); cmp("strel.pc", pc, 32'h400);
    cmp("strel.pend", 32'(branch_pending_o), 32'h0);
    step("st_rel1"); cmp("strel1.pc", pc, 32'h404);

    // Flush overrides stall, live branch and a buffered branch
    stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h300;
    step("pre_fl");
    flush = 1; new_pc = 32'h180; branch_target_address_i = 32'h500;
    step("flush"); cmp("flush.pc", pc, 32'h180);
    cmp("flush.pend", 32'(branch_pending_o), 32'h0);
    idle();
    step("flush1"); cmp("flush1.pc", pc, 32'h184);

    // Misaligned target and address wrap
    branch_flag_i = 1; branch_target_address_i = 32'h202;
    step("mis");   cmp("mis.flag", 32'(pc_misalign_o), 32'h1);
    idle();
    step("mis1");  cmp("mis1.pc", pc, 32'h206);
    cmp("mis1.flag", 32'(pc_misalign_o), 32'h1);
    flush = 1; new_pc = 32'hFFFF_FFFC;
    step("wrap0"); cmp("wrap0.flag", 32'(pc_misalign_o), 32'h0);
    idle();
    step("wrap1"); cmp("wrap1.pc", pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      stall                   = 6'($urandom_range(0, 63));
      flush                   = ($urandom_range(0, 15) == 0);
      new_pc                  = $urandom;
      branch_flag_i           = ($urandom_range(0, 3) == 0);
      branch_target_address_i = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step("rand");
    end

    // Async reset mid-run with a buffered branch
    idle();
    stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h700;
    step("pre_rst");
    cmp("prerst.pend", 32'(branch_pending_o), 32'h1);
    #3;
    rst = 0; model_reset();
    #1;
    check_model("async_rst");
    cmp("arst.pc", pc, RESET_VEC);
    cmp("arst.ce", 32'(ce), 32'h0);
    cmp("arst.pend", 32'(branch_pending_o), 32'h0);
    idle();
    step("rst_hold");
    rst = 1;
    step("reboot");
    step("reboot1"); cmp("reboot1.pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
